// File: rtl/bist_sequencer.sv
// BIST sequencer: drives SRSG/SISR scan test of a CUT and checks the final
// signature. Optional abort input when BIST_ABORT_EN is defined.
//
// Ports:
//   clk, rstIn            clock, async active-high reset
//   start, numPatterns    run request and pattern count (0 runs one pattern)
//   signature, goldenSig  SISR contents and expected signature
//   abort                 (BIST_ABORT_EN only) stop a run early, pass=0
//   NbarT, rstOut         test/normal mode select, CUT/SRSG/SISR reset
//   SRSG_En, SISR_En      generator / compactor enables
//   busy, done, pass      run status and registered verdict
module bist_sequencer #(
  parameter int SHIFT_SIZE  = 4,
  parameter int CAPTURE_CYC = 1,
  parameter int PAT_W       = 16,
  parameter int SIG_W       = 16
) (
  input  logic             clk,
  input  logic             rstIn,
  input  logic             start,
  input  logic [PAT_W-1:0] numPatterns,
  input  logic [SIG_W-1:0] signature,
  input  logic [SIG_W-1:0] goldenSig,
`ifdef BIST_ABORT_EN
  input  logic             abort,
`endif
  output logic             NbarT,
  output logic             rstOut,
  output logic             SRSG_En,
  output logic             SISR_En,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int SH_W = $clog2(SHIFT_SIZE + 1);
  localparam int CP_W = $clog2(CAPTURE_CYC + 1);
  localparam logic [SH_W-1:0] SH_LAST = SH_W'(SHIFT_SIZE - 1);
  localparam logic [CP_W-1:0] CP_LAST = CP_W'(CAPTURE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_GEN, S_SHIFT,
    S_CAP, S_SIG, S_CMP, S_DONE
  } state_t;

  state_t           r_state;
  logic [SH_W-1:0]  r_sh;
  logic [CP_W-1:0]  r_cap;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_lat;
  logic             r_pass;

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_cap   <= '0;
      r_pat   <= '0;
      r_lat   <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RST;
            r_lat   <= (numPatterns == '0) ? PAT_W'(1) : numPatterns;
            // verdict of the previous run is withdrawn as done drops
            r_pass  <= 1'b0;
          end
        end
        S_RST: begin
          r_pat   <= '0;
          r_pass  <= 1'b0;
          r_state <= S_GEN;
        end
        S_GEN: begin
          r_sh    <= '0;
          r_cap   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_sh <= r_sh + SH_W'(1);
          if (r_sh == SH_LAST) r_state <= S_CAP;
        end
        S_CAP: begin
          r_cap <= r_cap + CP_W'(1);
          if (r_cap == CP_LAST) r_state <= S_SIG;
        end
        S_SIG: begin
          r_pat <= r_pat + PAT_W'(1);
          // compare pre-increment count so 2**PAT_W-1 patterns never wrap
          if (r_pat < r_lat - PAT_W'(1)) r_state <= S_GEN;
          else                           r_state <= S_CMP;
        end
        S_CMP: begin
          r_pass  <= (signature == goldenSig);
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef BIST_ABORT_EN
      if (abort && r_state != S_IDLE && r_state != S_DONE) begin
        r_state <= S_DONE;
        r_pass  <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    NbarT   = 1'b0;
    rstOut  = 1'b0;
    SRSG_En = 1'b0;
    SISR_En = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_RST: begin
        rstOut = 1'b1;
        NbarT  = 1'b1;
        busy   = 1'b1;
      end
      S_GEN: begin
        SRSG_En = 1'b1;
        busy    = 1'b1;
      end
      S_SHIFT: begin
        SRSG_En = 1'b1;
        SISR_En = 1'b1;
        NbarT   = 1'b1;
        busy    = 1'b1;
      end
      S_CAP:  busy = 1'b1;
      S_SIG: begin
        SISR_En = 1'b1;
        busy    = 1'b1;
      end
      S_CMP:  busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign pass = r_pass;

endmodule
